// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int RTS_CYCLES     = 250,
   parameter int TIMEOUT_CYCLES = 750000,
   parameter int FILTER_LEN     = 8
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       tx_active,
   output logic       done,
   output logic       err,
   output logic [1:0] err_code,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe
);

   localparam int HOLD_MAX = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
   localparam int CW = $clog2(HOLD_MAX + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int FW = $clog2(FILTER_LEN + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_RTS,
      S_SHIFT,
      S_ACK,
      S_WAIT_IDLE
   } state_t;

   // line conditioning state
   logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
   logic          data_s1_q, data_s1_d, data_s2_q, data_s2_d;
   logic          clk_filt_q, clk_filt_d, data_filt_q, data_filt_d;
   logic [FW-1:0] clk_fcnt_q, clk_fcnt_d, data_fcnt_q, data_fcnt_d;
   logic          clk_prev_q, clk_prev_d;
   logic          fall;

   // transmitter state
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic [3:0]    bitcnt_q, bitcnt_d;
   logic [7:0]    tx_byte_q, tx_byte_d;
   logic          parity_q, parity_d;
   logic          clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
   logic          done_q, done_d, err_q, err_d;
   logic [1:0]    err_code_q, err_code_d;

   // synchronize both pads and accept a new level only after FILTER_LEN agreeing samples
   always_comb begin
      clk_s1_d    = ps2_clk_in;
      clk_s2_d    = clk_s1_q;
      data_s1_d   = ps2_data_in;
      data_s2_d   = data_s1_q;
      clk_filt_d  = clk_filt_q;
      clk_fcnt_d  = '0;
      data_filt_d = data_filt_q;
      data_fcnt_d = '0;
      if (clk_s2_q != clk_filt_q) begin
         if (clk_fcnt_q == FW'(FILTER_LEN - 1)) clk_filt_d = clk_s2_q;
         else                                   clk_fcnt_d = clk_fcnt_q + FW'(1);
      end
      if (data_s2_q != data_filt_q) begin
         if (data_fcnt_q == FW'(FILTER_LEN - 1)) data_filt_d = data_s2_q;
         else                                    data_fcnt_d = data_fcnt_q + FW'(1);
      end
      clk_prev_d = clk_filt_q;
   end

   // conditioning registers; idle pads are high, so filters reset to 1
   always_ff @(posedge clk) begin
      if (!rstn) begin
         clk_s1_q    <= 1'b1;
         clk_s2_q    <= 1'b1;
         data_s1_q   <= 1'b1;
         data_s2_q   <= 1'b1;
         clk_filt_q  <= 1'b1;
         data_filt_q <= 1'b1;
         clk_fcnt_q  <= '0;
         data_fcnt_q <= '0;
         clk_prev_q  <= 1'b1;
      end else begin
         clk_s1_q    <= clk_s1_d;
         clk_s2_q    <= clk_s2_d;
         data_s1_q   <= data_s1_d;
         data_s2_q   <= data_s2_d;
         clk_filt_q  <= clk_filt_d;
         data_filt_q <= data_filt_d;
         clk_fcnt_q  <= clk_fcnt_d;
         data_fcnt_q <= data_fcnt_d;
         clk_prev_q  <= clk_prev_d;
      end
   end

   assign fall = clk_prev_q & ~clk_filt_q;

   // next-state and output logic of the frame sequencer
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      to_cnt_d   = to_cnt_q;
      bitcnt_d   = bitcnt_q;
      tx_byte_d  = tx_byte_q;
      parity_d   = parity_q;
      clk_oe_d   = clk_oe_q;
      data_oe_d  = data_oe_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      err_code_d = err_code_q;
      case (state_q)
         S_IDLE: begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            if (tx_valid) begin
               tx_byte_d = tx_data;
               parity_d  = ~^tx_data;
               cnt_d     = '0;
               clk_oe_d  = 1'b1;
               state_d   = S_INHIBIT;
            end
         end
         S_INHIBIT: begin
            if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
               cnt_d     = '0;
               data_oe_d = 1'b1;
               state_d   = S_RTS;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_RTS: begin
            if (cnt_q == CW'(RTS_CYCLES - 1)) begin
               clk_oe_d = 1'b0;
               bitcnt_d = '0;
               to_cnt_d = '0;
               state_d  = S_SHIFT;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_SHIFT, S_ACK, S_WAIT_IDLE: begin
            if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
               clk_oe_d   = 1'b0;
               data_oe_d  = 1'b0;
               err_d      = 1'b1;
               err_code_d = 2'd1;
               state_d    = S_IDLE;
            end else begin
               to_cnt_d = to_cnt_q + TW'(1);
               if (state_q == S_SHIFT) begin
                  if (fall) begin
                     bitcnt_d = bitcnt_q + 4'd1;
                     if (bitcnt_q < 4'd8)       data_oe_d = ~tx_byte_q[bitcnt_q[2:0]];
                     else if (bitcnt_q == 4'd8) data_oe_d = ~parity_q;
                     else begin
                        data_oe_d = 1'b0;
                        state_d   = S_ACK;
                     end
                  end
               end else if (state_q == S_ACK) begin
                  if (fall) begin
                     if (!data_filt_q) begin
                        state_d = S_WAIT_IDLE;
                     end else begin
                        err_d      = 1'b1;
                        err_code_d = 2'd2;
                        data_oe_d  = 1'b0;
                        state_d    = S_IDLE;
                     end
                  end
               end else begin
                  if (clk_filt_q && data_filt_q) begin
                     done_d  = 1'b1;
                     state_d = S_IDLE;
                  end
               end
            end
         end
         default: begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            state_d   = S_IDLE;
         end
      endcase
   end

   // sequencer registers; reset releases both pads on the next edge
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         to_cnt_q   <= '0;
         bitcnt_q   <= '0;
         tx_byte_q  <= '0;
         parity_q   <= 1'b0;
         clk_oe_q   <= 1'b0;
         data_oe_q  <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         err_code_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         to_cnt_q   <= to_cnt_d;
         bitcnt_q   <= bitcnt_d;
         tx_byte_q  <= tx_byte_d;
         parity_q   <= parity_d;
         clk_oe_q   <= clk_oe_d;
         data_oe_q  <= data_oe_d;
         done_q     <= done_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
      end
   end

   assign tx_ready    = (state_q == S_IDLE);
   assign tx_active   = (state_q != S_IDLE);
   assign done        = done_q;
   assign err         = err_q;
   assign err_code    = err_code_q;
   assign ps2_clk_oe  = clk_oe_q;
   assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;

   localparam int INH  = 40;
   localparam int RTS  = 10;
   localparam int TO   = 2000;
   localparam int FL   = 8;
   localparam int HALF = 40;

   logic       clk = 1'b0;
   logic       rstn;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready, tx_active, done, err;
   logic [1:0] err_code;
   logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;

   logic dev_clk_low = 1'b0, dev_data_low = 1'b0, glitch = 1'b0;
   bit   dev_ack = 1'b1, dev_clocks = 1'b1, glitch_en = 1'b0, dev_busy = 1'b0;
   int   dev_bits = 0;
   logic [10:0] dev_frame;
   logic [10:0] frames_q[$];

   int n_chk = 0, n_fail = 0;
   int cyc = 0, done_cnt = 0, err_cnt = 0;
   int t_clk_rise = 0, t_data_rise = 0, t_clk_fall = 0;
   logic clk_oe_p = 1'b0, data_oe_p = 1'b0;

   typedef struct {
      logic [7:0] data;
      bit         ack;
      bit         clocks;
      bit         glitch;
      logic [1:0] exp_code;
      bit         exp_done;
   } vec_t;
   vec_t vecs[6];

   assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low | glitch);
   assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .RTS_CYCLES(RTS), .TIMEOUT_CYCLES(TO), .FILTER_LEN(FL)) dut (
      .clk(clk), .rstn(rstn), .tx_valid(tx_valid), .tx_data(tx_data),
      .tx_ready(tx_ready), .tx_active(tx_active), .done(done), .err(err), .err_code(err_code),
      .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
      .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      clk_oe_p  <= ps2_clk_oe;
      data_oe_p <= ps2_data_oe;
      if (ps2_clk_oe && !clk_oe_p) t_clk_rise <= cyc;
      if (ps2_data_oe && !data_oe_p && ps2_clk_oe) t_data_rise <= cyc;
      if (!ps2_clk_oe && clk_oe_p) t_clk_fall <= cyc;
      if (done) done_cnt <= done_cnt + 1;
      if (err) err_cnt <= err_cnt + 1;
   end

   task automatic half_high();
      for (int i = 0; i < HALF; i++) begin
         glitch = glitch_en && (i == HALF / 2);
         @(negedge clk);
      end
      glitch = 1'b0;
   endtask

   always begin
      @(negedge clk);
      if (rstn && dev_clocks && ps2_clk_in && !ps2_data_in) begin
         dev_bits  = 0;
         dev_busy  = 1'b1;
         dev_frame = '0;
         dev_frame[0] = ps2_data_in;
         half_high();
         for (int k = 1; k <= 11; k++) begin
            if (k == 11 && dev_ack) dev_data_low = 1'b1;
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            if (k <= 10) begin
               dev_frame[k] = ps2_data_in;
               dev_bits = k;
            end
            half_high();
         end
         dev_data_low = 1'b0;
         frames_q.push_back(dev_frame);
         dev_busy = 1'b0;
      end
   end

   function automatic logic [10:0] model_frame(input logic [7:0] d);
      int ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(d[i]);
      return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d, 1'b0};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_end(output bit ok, output bit gd, output bit ge, output logic [1:0] code,
                           output logic [1:0] oe, output logic rdy, output int tend);
      ok = 0; gd = 0; ge = 0; code = 0; oe = 0; rdy = 0; tend = 0;
      for (int i = 0; i < 5000 && !ok; i++) begin
         @(negedge clk);
         if (done || err) begin
            ok = 1; gd = done; ge = err; code = err_code;
            oe = {ps2_clk_oe, ps2_data_oe}; rdy = tx_ready; tend = cyc;
         end
      end
   endtask

   task automatic wait_dev_idle(input string tag);
      for (int i = 0; i < 3000 && dev_busy; i++) @(negedge clk);
      chk({tag, ".dev_idle"}, dev_busy, 0);
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int d0, e0, tend;
      bit ok, gd, ge;
      logic [1:0] code, oe;
      logic rdy;
      dev_ack = v.ack; dev_clocks = v.clocks; glitch_en = v.glitch;
      frames_q.delete();
      d0 = done_cnt; e0 = err_cnt;
      @(negedge clk); tx_valid = 1'b1; tx_data = v.data;
      @(negedge clk); tx_valid = 1'b0; tx_data = 8'($urandom);
      chk({tag, ".busy"}, {tx_active, tx_ready}, 2'b10);
      wait_end(ok, gd, ge, code, oe, rdy, tend);
      chk({tag, ".ended"}, ok, 1);
      chk({tag, ".done"}, gd, v.exp_done);
      chk({tag, ".err"}, ge, !v.exp_done);
      if (ge) chk({tag, ".err_code"}, code, v.exp_code);
      chk({tag, ".oe_end"}, oe, 2'b00);
      chk({tag, ".ready_end"}, rdy, 1);
      chk({tag, ".inhibit_len"}, t_data_rise - t_clk_rise, INH);
      chk({tag, ".rts_len"}, t_clk_fall - t_data_rise, RTS);
      if (!v.clocks) chk({tag, ".timeout_len"}, tend - t_clk_fall, TO);
      wait_dev_idle(tag);
      repeat (20) @(negedge clk);
      chk({tag, ".done_pulses"}, done_cnt - d0, v.exp_done ? 1 : 0);
      chk({tag, ".err_pulses"}, err_cnt - e0, v.exp_done ? 0 : 1);
      chk({tag, ".frames"}, frames_q.size(), v.clocks ? 1 : 0);
      if (v.clocks && frames_q.size() > 0) chk({tag, ".frame"}, frames_q[0], model_frame(v.data));
      if (!v.exp_done) chk({tag, ".code_hold"}, err_code, v.exp_code);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int d0, e0, tend;
      bit ok, gd, ge;
      logic [1:0] code, oe;
      logic rdy;
      vec_t rv;

      rstn = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
      vecs[0] = '{8'hF4, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1};
      vecs[1] = '{8'hFF, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1};
      vecs[2] = '{8'h00, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1};
      vecs[3] = '{8'hA5, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0};
      vecs[4] = '{8'h3C, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0};
      vecs[5] = '{8'h96, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1};

      repeat (4) @(negedge clk);
      chk("reset.tx_ready", tx_ready, 1);
      chk("reset.tx_active", tx_active, 0);
      chk("reset.done_err", {done, err}, 2'b00);
      chk("reset.err_code", err_code, 0);
      chk("reset.oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
      rstn = 1'b1;
      repeat (20) @(negedge clk);

      for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      for (int i = 0; i < 4; i++) begin
         rv.data     = 8'($urandom);
         rv.ack      = 1'b1;
         rv.clocks   = 1'b1;
         rv.glitch   = 1'($urandom_range(0, 1));
         rv.exp_code = 2'd0;
         rv.exp_done = 1'b1;
         run_vec(rv, $sformatf("rand%0d", i));
      end

      // tx_valid held through a whole frame with tx_data changing mid-frame
      dev_ack = 1'b1; dev_clocks = 1'b1; glitch_en = 1'b0;
      frames_q.delete();
      d0 = done_cnt; e0 = err_cnt;
      @(negedge clk); tx_valid = 1'b1; tx_data = 8'h5A;
      @(negedge clk); tx_data = 8'hFF;
      wait_end(ok, gd, ge, code, oe, rdy, tend);
      tx_valid = 1'b0;
      chk("hold.done", gd, 1);
      wait_dev_idle("hold");
      repeat (30) @(negedge clk);
      chk("hold.frames", frames_q.size(), 1);
      if (frames_q.size() > 0) chk("hold.frame", frames_q[0], model_frame(8'h5A));
      chk("hold.done_pulses", done_cnt - d0, 1);
      chk("hold.err_pulses", err_cnt - e0, 0);
      chk("hold.idle", {tx_active, tx_ready}, 2'b01);

      // reset asserted while the device is clocking bit 4
      frames_q.delete();
      d0 = done_cnt; e0 = err_cnt;
      @(negedge clk); tx_valid = 1'b1; tx_data = 8'hC3;
      @(negedge clk); tx_valid = 1'b0;
      for (int i = 0; i < 3000 && !dev_busy; i++) @(negedge clk);
      for (int i = 0; i < 3000 && dev_bits < 4; i++) @(negedge clk);
      chk("rst.reached_bit4", dev_bits, 4);
      rstn = 1'b0;
      @(negedge clk);
      chk("rst.oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
      chk("rst.active", tx_active, 0);
      rstn = 1'b1;
      wait_dev_idle("rst");
      repeat (30) @(negedge clk);
      chk("rst.done_pulses", done_cnt - d0, 0);
      chk("rst.err_pulses", err_cnt - e0, 0);
      chk("rst.ready", tx_ready, 1);
      frames_q.delete();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
